// File: rtl/motor_sequencer_if.sv
// Command/drive bundle between the wall-following controller and the motor sequencer.
// The master issues the command levels; the slave (sequencer) returns the H-bridge drives and status.
interface motor_sequencer_if;
  logic avancar;
  logic girar;
  logic remover;
  logic roda_esq_fwd;
  logic roda_esq_rev;
  logic roda_dir_fwd;
  logic roda_dir_rev;
  logic braco;
  logic ocupado;
  logic movimento_ok;
  logic erro;

  modport master (
    output avancar, girar, remover,
    input  roda_esq_fwd, roda_esq_rev, roda_dir_fwd, roda_dir_rev,
    input  braco, ocupado, movimento_ok, erro
  );

  modport slave (
    input  avancar, girar, remover,
    output roda_esq_fwd, roda_esq_rev, roda_dir_fwd, roda_dir_rev,
    output braco, ocupado, movimento_ok, erro
  );
endinterface

// File: rtl/motor_sequencer.sv
// Turns accepted avancar/girar/remover commands into timed H-bridge bursts, inserting
// dead time on wheel-direction reversal and latching illegal avancar+girar combinations.
module motor_sequencer #(
  parameter int AVANCA_CICLOS = 8,
  parameter int GIRO_CICLOS   = 12,
  parameter int REMOVE_CICLOS = 4,
  parameter int DEAD_CICLOS   = 2
) (
  input logic              clockc2,
  input logic              reset,
  motor_sequencer_if.slave bus
);
  localparam int MAX_AG = (AVANCA_CICLOS > GIRO_CICLOS) ? AVANCA_CICLOS : GIRO_CICLOS;
  localparam int MAX_RD = (REMOVE_CICLOS > DEAD_CICLOS) ? REMOVE_CICLOS : DEAD_CICLOS;
  localparam int MAXC   = (MAX_AG > MAX_RD) ? MAX_AG : MAX_RD;
  localparam int CW     = $clog2(MAXC + 1);

  localparam logic [CW-1:0] AV_LD = CW'(AVANCA_CICLOS - 1);
  localparam logic [CW-1:0] GI_LD = CW'(GIRO_CICLOS - 1);
  localparam logic [CW-1:0] RM_LD = CW'(REMOVE_CICLOS - 1);
  localparam logic [CW-1:0] DD_LD = CW'(DEAD_CICLOS - 1);

  typedef enum logic [2:0] {S_IDLE, S_DEAD, S_AVANCA, S_GIRA, S_REMOVE} state_t;
  typedef enum logic [1:0] {D_NONE, D_FWD, D_TURN} dir_t;

  state_t        state_q, state_d;
  dir_t          last_dir_q, last_dir_d;
  dir_t          tgt_q, tgt_d;
  dir_t          cmd_dir;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          erro_q, erro_d;
  logic          esq_fwd_q, esq_fwd_d;
  logic          esq_rev_q, esq_rev_d;
  logic          dir_fwd_q, dir_fwd_d;
  logic          braco_q, braco_d;
  logic          ocupado_q, ocupado_d;
  logic          mov_ok_q, mov_ok_d;

  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    erro_d     = erro_q;
    cmd_dir    = bus.avancar ? D_FWD : D_TURN;
    case (state_q)
      S_IDLE: begin
        if (bus.remover) begin
          state_d = S_REMOVE;
          cnt_d   = RM_LD;
        end else if (bus.avancar && bus.girar) begin
          erro_d = 1'b1;
        end else if (bus.avancar || bus.girar) begin
          if (last_dir_q == D_NONE || last_dir_q == cmd_dir) begin
            state_d    = (cmd_dir == D_FWD) ? S_AVANCA : S_GIRA;
            cnt_d      = (cmd_dir == D_FWD) ? AV_LD : GI_LD;
            last_dir_d = cmd_dir;
          end else begin
            state_d = S_DEAD;
            cnt_d   = DD_LD;
            tgt_d   = cmd_dir;
          end
        end
      end
      S_DEAD: begin
        if (cnt_q == '0) begin
          state_d    = (tgt_q == D_FWD) ? S_AVANCA : S_GIRA;
          cnt_d      = (tgt_q == D_FWD) ? AV_LD : GI_LD;
          last_dir_d = tgt_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
    endcase
    // Drives are decoded from the next state so they change on the same edge as the state.
    esq_fwd_d = (state_d == S_AVANCA);
    esq_rev_d = (state_d == S_GIRA);
    dir_fwd_d = (state_d == S_AVANCA) || (state_d == S_GIRA);
    braco_d   = (state_d == S_REMOVE);
    ocupado_d = (state_d != S_IDLE);
    mov_ok_d  = (state_d == S_IDLE) &&
                (state_q == S_AVANCA || state_q == S_GIRA || state_q == S_REMOVE);
  end

  always_ff @(posedge clockc2 or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      last_dir_q <= D_NONE;
      tgt_q      <= D_NONE;
      cnt_q      <= '0;
      erro_q     <= 1'b0;
      esq_fwd_q  <= 1'b0;
      esq_rev_q  <= 1'b0;
      dir_fwd_q  <= 1'b0;
      braco_q    <= 1'b0;
      ocupado_q  <= 1'b0;
      mov_ok_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      erro_q     <= erro_d;
      esq_fwd_q  <= esq_fwd_d;
      esq_rev_q  <= esq_rev_d;
      dir_fwd_q  <= dir_fwd_d;
      braco_q    <= braco_d;
      ocupado_q  <= ocupado_d;
      mov_ok_q   <= mov_ok_d;
    end
  end

  // The turn spins the left wheel backwards only, so the right wheel never reverses.
  assign bus.roda_esq_fwd = esq_fwd_q;
  assign bus.roda_esq_rev = esq_rev_q;
  assign bus.roda_dir_fwd = dir_fwd_q;
  assign bus.roda_dir_rev = 1'b0;
  assign bus.braco        = braco_q;
  assign bus.ocupado      = ocupado_q;
  assign bus.movimento_ok = mov_ok_q;
  assign bus.erro         = erro_q;
endmodule
